rv32_issue_scoreboard: RTL and testbench
========================================

Name: rv32_issue_scoreboard

Overview:
- Sits between decode and execute. Tracks destination registers still owed by multi-cycle units (load, MUL, GRNG).
- Stalls decode on RAW/WAW hazards and serialises Zicsr instructions by draining in-flight writers first.
- Consumes the decoder's `control` and `use_rs` outputs plus rs1/rs2/rd fields. Drives the decode-stage stall and issue strobe.

Parameters:
- NUM_REGS, 32, architectural integer registers; x0 is never tracked.
- CNT_W, 3, width of each per-register pending counter.
- LOAD_LAT, 2, cycles from issue until a load result is forwardable.
- MUL_LAT, 3, cycles from issue until a MUL result is forwardable.
- GRNG_LAT, 1, cycles from issue until a GRNG result is forwardable.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- dec_valid  in  1  decode holds a valid instruction
- dec_rs1, dec_rs2, dec_rd  in  5 each  register indices
- dec_use_rs  in  3  rs1, rs2, rs3(=rd) usage flags from decoder
- dec_register_wb  in  1  instruction writes rd (already 0 for rd==x0)
- dec_csr_wb  in  1  Zicsr instruction
- dec_wb_src  in  wb_result_src_t  writeback source selector
- ex_stall  in  1  downstream backpressure; freezes counters and blocks issue
- flush  in  1  kill decode-stage instruction this cycle
- stall_decode  out  1  hold decode/fetch
- issue  out  1  instruction accepted into execute this cycle
- busy_mask  out  NUM_REGS  bit i set when counter[i] != 0
- drain_active  out  1  FSM in DRAIN

Behaviour:
- Reset:
  - All counters 0; FSM = RUN.
  - stall_decode=0, issue=0, busy_mask=0, drain_active=0.
  - rst has priority over every other input.
- Latency lookup `lat(src)`:
  - WB_MEM_DATA → LOAD_LAT; WB_MUL_UNIT → MUL_LAT; WB_GRNG → GRNG_LAT.
  - All other sources → 0 (fully forwarded, not tracked).
- Hazards (combinational):
  - raw = any used rs (rs1, rs2, rd for index 2) with index != 0 and counter != 0.
  - waw = dec_register_wb and counter[rd] > lat(src).
- FSM RUN:
  - can_issue = dec_valid & !flush & !ex_stall & !raw & !waw.
  - If dec_csr_wb & dec_valid & !flush & (busy_mask != 0): go to DRAIN; no issue this cycle.
  - Otherwise issue = can_issue.
  - stall_decode = dec_valid & !flush & !issue.
- FSM DRAIN:
  - issue=0, stall_decode=1, drain_active=1.
  - When busy_mask==0 and !ex_stall: return to RUN. The CSR instruction then issues the next cycle through the normal RUN rules.
  - flush in DRAIN returns to RUN immediately.
- Counter update, per register each cycle, in priority order:
  1. rst clears.
  2. ex_stall holds.
  3. On issue with dec_register_wb, rd!=0 and lat!=0: counter[rd] ← lat.
  4. Otherwise decrement if nonzero; saturate at 0.
- Issue-load vs decrement on the same register in the same cycle: the load wins.
- flush never clears counters; older in-flight writers still complete.
- Counters are CNT_W bits wide. Elaboration asserts every latency < 2^CNT_W.
- busy_mask is registered-counter derived, so it is not delayed by issue.

Decomposition:
- rv32_types gains:
  - scoreboard FSM enum `sb_state_t {SB_RUN, SB_DRAIN}`.
  - latency constants LAT_LOAD/LAT_MUL/LAT_GRNG (defaults for the parameters).
  - function `wb_src_latency(wb_result_src_t)`.
- One sub-module, `rv32_sb_counter`: a single CNT_W-bit load/decrement/hold counter, instantiated NUM_REGS-1 times via generate (x0 tied to 0).

Test Plan:
- Load to x5 issued, next instr `add x6,x5,x1` → stall_decode=1 for 2 cycles, issue on cycle 3; busy_mask[5] high for exactly 2 cycles.
- MUL to x7 then load to x7 → waw (3>2) stalls until counter[7]≤2, then issue. Then counter[7]=2.
- `csrrw x3` with MUL pending on x9 → drain_active=1 for 3 cycles, return to RUN, CSR issues next cycle; no issue during DRAIN.
- ex_stall held 4 cycles with load pending on x4 → counter[4] frozen at 2; released → decrements 2,1,0; dependent issues after.
- Instruction with rd=x0 from MUL, then reader of x0 → no tracking; busy_mask stays 0; no stall.
- rst asserted mid-DRAIN with counters nonzero → next cycle FSM=RUN, busy_mask=0, all outputs 0.

Source files
------------

// File: rtl/rv32_issue_scoreboard_pkg.sv
// Shared types for the issue scoreboard: writeback source selector, scoreboard
// FSM states and the default latencies of the multi-cycle result producers.
package rv32_issue_scoreboard_pkg;

  typedef enum logic [2:0] {
    WB_ALU_RESULT = 3'd0,
    WB_MEM_DATA   = 3'd1,
    WB_PC_PLUS4   = 3'd2,
    WB_IMM        = 3'd3,
    WB_CSR_DATA   = 3'd4,
    WB_MUL_UNIT   = 3'd5,
    WB_GRNG       = 3'd6
  } wb_result_src_t;

  typedef enum logic {
    SB_RUN   = 1'b0,
    SB_DRAIN = 1'b1
  } sb_state_t;

  localparam int unsigned LAT_LOAD = 2;
  localparam int unsigned LAT_MUL  = 3;
  localparam int unsigned LAT_GRNG = 1;

  // Sources not listed are forwarded in time and never need tracking.
  function automatic int unsigned wb_src_latency(input wb_result_src_t src,
                                                 input int unsigned    load_lat,
                                                 input int unsigned    mul_lat,
                                                 input int unsigned    grng_lat);
    case (src)
      WB_MEM_DATA: return load_lat;
      WB_MUL_UNIT: return mul_lat;
      WB_GRNG:     return grng_lat;
      default:     return 0;
    endcase
  endfunction

endpackage

// File: rtl/rv32_sb_counter.sv
// One pending-writer counter: load beats decrement, ex_stall freezes it,
// and it saturates at zero.
module rv32_sb_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] count_o,
  output logic             busy_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (hold_i) begin
      cnt_d = cnt_q;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
  assign busy_o  = (cnt_q != '0);

endmodule

// File: rtl/rv32_issue_scoreboard.sv
// Decode-to-execute scoreboard: stalls on RAW/WAW against registers still owed
// by multi-cycle units and drains all in-flight writers before a Zicsr issues.
module rv32_issue_scoreboard
  import rv32_issue_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned CNT_W    = 3,
  parameter int unsigned LOAD_LAT = LAT_LOAD,
  parameter int unsigned MUL_LAT  = LAT_MUL,
  parameter int unsigned GRNG_LAT = LAT_GRNG
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dec_valid,
  input  logic [4:0]          dec_rs1,
  input  logic [4:0]          dec_rs2,
  input  logic [4:0]          dec_rd,
  input  logic [2:0]          dec_use_rs,
  input  logic                dec_register_wb,
  input  logic                dec_csr_wb,
  input  wb_result_src_t      dec_wb_src,
  input  logic                ex_stall,
  input  logic                flush,
  output logic                stall_decode,
  output logic                issue,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                drain_active
);

  if (LOAD_LAT >= (32'd1 << CNT_W) || MUL_LAT >= (32'd1 << CNT_W) ||
      GRNG_LAT >= (32'd1 << CNT_W)) begin : g_bad_latency
    $error("rv32_issue_scoreboard: a latency does not fit in CNT_W bits");
  end

  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [CNT_W-1:0] src_lat;
  logic             rs1_hit, rs2_hit, rd_hit;
  logic             raw, waw, can_issue, csr_drain;
  sb_state_t        state_q, state_d;

  assign src_lat = CNT_W'(wb_src_latency(dec_wb_src, LOAD_LAT, MUL_LAT, GRNG_LAT));

  // rs3 shares the rd field, so a read-modify-write of rd is a RAW on rd.
  assign rs1_hit   = dec_use_rs[0] && (dec_rs1 != 5'd0) && busy_mask[dec_rs1];
  assign rs2_hit   = dec_use_rs[1] && (dec_rs2 != 5'd0) && busy_mask[dec_rs2];
  assign rd_hit    = dec_use_rs[2] && (dec_rd  != 5'd0) && busy_mask[dec_rd];
  assign raw       = rs1_hit || rs2_hit || rd_hit;
  assign waw       = dec_register_wb && (cnt[dec_rd] > src_lat);
  assign can_issue = dec_valid && !flush && !ex_stall && !raw && !waw;
  assign csr_drain = dec_csr_wb && dec_valid && !flush && (busy_mask != '0);

  assign cnt[0]       = '0;
  assign busy_mask[0] = 1'b0;

  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
    rv32_sb_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .hold_i    (ex_stall),
      .load_i    (issue && dec_register_wb && (dec_rd == 5'(gi)) && (src_lat != '0)),
      .load_val_i(src_lat),
      .count_o   (cnt[gi]),
      .busy_o    (busy_mask[gi])
    );
  end

  always_comb begin
    state_d      = state_q;
    issue        = 1'b0;
    stall_decode = 1'b0;
    case (state_q)
      SB_RUN: begin
        if (csr_drain) begin
          state_d = SB_DRAIN;
        end else begin
          issue = can_issue;
        end
        stall_decode = dec_valid && !flush && !issue;
      end
      SB_DRAIN: begin
        stall_decode = 1'b1;
        if (flush || ((busy_mask == '0) && !ex_stall)) begin
          state_d = SB_RUN;
        end
      end
      default: state_d = SB_RUN;
    endcase
    // Reset overrides everything, including a valid instruction on decode.
    if (rst) begin
      issue        = 1'b0;
      stall_decode = 1'b0;
      state_d      = SB_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= SB_RUN;
    else     state_q <= state_d;
  end

  assign drain_active = (state_q == SB_DRAIN);

endmodule

// File: tb/tb_rv32_issue_scoreboard.sv
// Self-checking bench: directed scenarios with hand-derived expectations, then
// a randomized run against a per-register "cycles still owed" reference model.
module tb_rv32_issue_scoreboard;
  import rv32_issue_scoreboard_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           dec_valid;
  logic [4:0]     dec_rs1, dec_rs2, dec_rd;
  logic [2:0]     dec_use_rs;
  logic           dec_register_wb;
  logic           dec_csr_wb;
  wb_result_src_t dec_wb_src;
  logic           ex_stall;
  logic           flush;
  logic           stall_decode;
  logic           issue;
  logic [31:0]    busy_mask;
  logic           drain_active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32_issue_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .dec_valid      (dec_valid),
    .dec_rs1        (dec_rs1),
    .dec_rs2        (dec_rs2),
    .dec_rd         (dec_rd),
    .dec_use_rs     (dec_use_rs),
    .dec_register_wb(dec_register_wb),
    .dec_csr_wb     (dec_csr_wb),
    .dec_wb_src     (dec_wb_src),
    .ex_stall       (ex_stall),
    .flush          (flush),
    .stall_decode   (stall_decode),
    .issue          (issue),
    .busy_mask      (busy_mask),
    .drain_active   (drain_active)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_use_rs = 0;
    dec_register_wb = 0; dec_csr_wb = 0; dec_wb_src = WB_ALU_RESULT;
    ex_stall = 0; flush = 0;
  endtask

  task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [2:0] use_rs, input logic wb, input logic csr,
                           input wb_result_src_t src);
    dec_valid = 1; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd; dec_use_rs = use_rs;
    dec_register_wb = wb; dec_csr_wb = csr; dec_wb_src = src;
  endtask

  task automatic test_reset();
    rst = 1;
    idle();
    tick();
    set_instr(5'd1, 5'd2, 5'd3, 3'b011, 1'b1, 1'b0, WB_ALU_RESULT);
    @(negedge clk);
    checks++;
    if ({issue, stall_decode, drain_active, busy_mask} !== {3'b000, 32'h0}) begin
      errors++;
      $display("FAIL reset_hold got issue=%0b stall=%0b drain=%0b busy=%h want all 0",
               issue, stall_decode, drain_active, busy_mask);
    end
    tick();
    rst = 0;
    idle();
    @(negedge clk);
    checks++;
    if ({issue, stall_decode, drain_active, busy_mask} !== {3'b000, 32'h0}) begin
      errors++;
      $display("FAIL reset_release got issue=%0b stall=%0b drain=%0b busy=%h want all 0",
               issue, stall_decode, drain_active, busy_mask);
    end
    tick();
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    logic [2:0] exp;
    set_instr(5'd1, 5'd0, 5'd5, 3'b001, 1'b1, 1'b0, WB_MEM_DATA);
    @(negedge clk);
    checks++;
    if (issue !== 1'b1) begin
      errors++;
      $display("FAIL load_use_load_issue got %0b want 1", issue);
    end
    tick();
    set_instr(5'd5, 5'd1, 5'd6, 3'b011, 1'b1, 1'b0, WB_ALU_RESULT);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp = (k == 2) ? 3'b100 : 3'b011;
      checks++;
      if ({issue, stall_decode, busy_mask[5]} !== exp) begin
        errors++;
        $display("FAIL load_use_cyc%0d got issue/stall/busy5=%b want %b", k,
                 {issue, stall_decode, busy_mask[5]}, exp);
      end
      tick();
    end
    idle();
    $display("test_load_use done");
  endtask

  task automatic test_waw();
    set_instr(5'd1, 5'd2, 5'd7, 3'b011, 1'b1, 1'b0, WB_MUL_UNIT);
    tick();
    set_instr(5'd1, 5'd0, 5'd7, 3'b001, 1'b1, 1'b0, WB_MEM_DATA);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({issue, stall_decode} !== ((k == 1) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL waw_cyc%0d got issue/stall=%b want %b", k, {issue, stall_decode},
                 (k == 1) ? 2'b10 : 2'b01);
      end
      tick();
    end
    idle();
    // The load reloaded counter[7] to 2: busy for two more cycles.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (busy_mask[7] !== (k < 2)) begin
        errors++;
        $display("FAIL waw_busy7_cyc%0d got %0b want %0b", k, busy_mask[7], (k < 2));
      end
      tick();
    end
    $display("test_waw done");
  endtask

  task automatic test_csr_drain();
    int drain_cycles = 0;
    int issue_cycle  = -1;
    set_instr(5'd1, 5'd2, 5'd9, 3'b011, 1'b1, 1'b0, WB_MUL_UNIT);
    tick();
    set_instr(5'd2, 5'd0, 5'd3, 3'b001, 1'b1, 1'b1, WB_CSR_DATA);
    for (int k = 0; k < 8 && issue_cycle < 0; k++) begin
      @(negedge clk);
      if (drain_active) begin
        drain_cycles++;
        checks++;
        if ({issue, stall_decode} !== 2'b01) begin
          errors++;
          $display("FAIL csr_drain_outputs cyc%0d got issue/stall=%b want 01", k,
                   {issue, stall_decode});
        end
      end
      if (issue) issue_cycle = k;
      tick();
    end
    idle();
    checks++;
    if (drain_cycles !== 3) begin
      errors++;
      $display("FAIL csr_drain_len got %0d want 3", drain_cycles);
    end
    checks++;
    if (issue_cycle !== 4) begin
      errors++;
      $display("FAIL csr_issue_cycle got %0d want 4", issue_cycle);
    end
    $display("test_csr_drain done");
  endtask

  task automatic test_ex_stall();
    set_instr(5'd1, 5'd0, 5'd4, 3'b001, 1'b1, 1'b0, WB_MEM_DATA);
    tick();
    set_instr(5'd4, 5'd0, 5'd8, 3'b001, 1'b1, 1'b0, WB_ALU_RESULT);
    ex_stall = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({issue, stall_decode, busy_mask[4]} !== 3'b011) begin
        errors++;
        $display("FAIL ex_stall_hold_cyc%0d got issue/stall/busy4=%b want 011", k,
                 {issue, stall_decode, busy_mask[4]});
      end
      tick();
    end
    ex_stall = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({issue, stall_decode, busy_mask[4]} !== ((k == 2) ? 3'b100 : 3'b011)) begin
        errors++;
        $display("FAIL ex_stall_release_cyc%0d got issue/stall/busy4=%b want %b", k,
                 {issue, stall_decode, busy_mask[4]}, (k == 2) ? 3'b100 : 3'b011);
      end
      tick();
    end
    idle();
    $display("test_ex_stall done");
  endtask

  task automatic test_x0();
    set_instr(5'd1, 5'd2, 5'd0, 3'b011, 1'b0, 1'b0, WB_MUL_UNIT);
    @(negedge clk);
    checks++;
    if (issue !== 1'b1) begin
      errors++;
      $display("FAIL x0_mul_issue got %0b want 1", issue);
    end
    tick();
    set_instr(5'd0, 5'd0, 5'd10, 3'b011, 1'b1, 1'b0, WB_ALU_RESULT);
    @(negedge clk);
    checks++;
    if ({issue, stall_decode, busy_mask} !== {2'b10, 32'h0}) begin
      errors++;
      $display("FAIL x0_reader got issue=%0b stall=%0b busy=%h want 1 0 0",
               issue, stall_decode, busy_mask);
    end
    tick();
    idle();
    $display("test_x0 done");
  endtask

  task automatic test_reset_mid_drain();
    set_instr(5'd1, 5'd2, 5'd9, 3'b011, 1'b1, 1'b0, WB_MUL_UNIT);
    tick();
    set_instr(5'd2, 5'd0, 5'd3, 3'b001, 1'b1, 1'b1, WB_CSR_DATA);
    tick();
    @(negedge clk);
    checks++;
    if ({drain_active, busy_mask[9]} !== 2'b11) begin
      errors++;
      $display("FAIL mid_drain_entry got drain/busy9=%b want 11", {drain_active, busy_mask[9]});
    end
    tick();
    rst = 1;
    @(negedge clk);
    checks++;
    if ({issue, stall_decode} !== 2'b00) begin
      errors++;
      $display("FAIL mid_drain_rst_outputs got issue/stall=%b want 00", {issue, stall_decode});
    end
    tick();
    rst = 0;
    idle();
    @(negedge clk);
    checks++;
    if ({issue, stall_decode, drain_active, busy_mask} !== {3'b000, 32'h0}) begin
      errors++;
      $display("FAIL mid_drain_after_rst got issue=%0b stall=%0b drain=%0b busy=%h want all 0",
               issue, stall_decode, drain_active, busy_mask);
    end
    tick();
    $display("test_reset_mid_drain done");
  endtask

  function automatic int model_lat(input wb_result_src_t src);
    if (src == WB_MEM_DATA) return 2;
    if (src == WB_MUL_UNIT) return 3;
    if (src == WB_GRNG)     return 1;
    return 0;
  endfunction

  task automatic test_random();
    int          pend [32];
    bit          m_drain;
    bit          nxt_drain, raw, waw, any_busy, e_issue, e_stall, e_drain;
    int          lat;
    logic [31:0] e_mask;
    rst = 1;
    idle();
    tick();
    rst = 0;
    for (int i = 0; i < 32; i++) pend[i] = 0;
    m_drain = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst             = ($urandom_range(0, 99) == 0);
      dec_valid       = ($urandom_range(0, 3) != 0);
      dec_rs1         = 5'($urandom_range(0, 7));
      dec_rs2         = 5'($urandom_range(0, 7));
      dec_rd          = 5'($urandom_range(0, 7));
      dec_use_rs      = 3'($urandom_range(0, 7));
      dec_wb_src      = wb_result_src_t'($urandom_range(0, 6));
      dec_register_wb = (dec_rd != 0) && ($urandom_range(0, 3) != 0);
      dec_csr_wb      = ($urandom_range(0, 15) == 0);
      ex_stall        = ($urandom_range(0, 4) == 0);
      flush           = ($urandom_range(0, 9) == 0);

      lat = model_lat(dec_wb_src);
      raw = (dec_use_rs[0] && dec_rs1 != 0 && pend[dec_rs1] != 0) ||
            (dec_use_rs[1] && dec_rs2 != 0 && pend[dec_rs2] != 0) ||
            (dec_use_rs[2] && dec_rd  != 0 && pend[dec_rd]  != 0);
      waw = dec_register_wb && (pend[dec_rd] > lat);
      any_busy = 0;
      e_mask   = '0;
      for (int i = 1; i < 32; i++) begin
        if (pend[i] != 0) begin
          any_busy  = 1;
          e_mask[i] = 1'b1;
        end
      end
      if (rst) begin
        e_issue = 0; e_stall = 0; nxt_drain = 0;
      end else if (!m_drain) begin
        nxt_drain = dec_csr_wb && dec_valid && !flush && any_busy;
        e_issue   = !nxt_drain && dec_valid && !flush && !ex_stall && !raw && !waw;
        e_stall   = dec_valid && !flush && !e_issue;
      end else begin
        e_issue   = 0;
        e_stall   = 1;
        nxt_drain = !(flush || (!any_busy && !ex_stall));
      end
      e_drain = m_drain;

      @(negedge clk);
      checks++;
      if ({issue, stall_decode, drain_active} !== {e_issue, e_stall, e_drain}) begin
        errors++;
        $display("FAIL rand_ctrl cyc%0d got issue/stall/drain=%b want %b", cyc,
                 {issue, stall_decode, drain_active}, {e_issue, e_stall, e_drain});
      end
      checks++;
      if (busy_mask !== e_mask) begin
        errors++;
        $display("FAIL rand_busy cyc%0d got %h want %h", cyc, busy_mask, e_mask);
      end
      if (e_issue)
        $display("rand cyc%0d issue rd=x%0d src=%s", cyc, dec_rd, dec_wb_src.name());

      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < 32; i++) pend[i] = 0;
      end else if (!ex_stall) begin
        for (int i = 1; i < 32; i++) begin
          if (e_issue && dec_register_wb && dec_rd == 5'(i) && lat != 0) pend[i] = lat;
          else if (pend[i] > 0) pend[i] = pend[i] - 1;
        end
      end
      m_drain = nxt_drain;
      #1;
    end
    rst = 0;
    idle();
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_waw();
    test_csr_drain();
    test_ex_stall();
    test_x0();
    test_reset_mid_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
